memory_ctrl: RTL and testbench
==============================

// Module: memory_ctrl
// PURPOSE
//  Initiator for the memory unit port (op/select/addr/data_in/data_out). Accepts one
//  read/write request at a time on a valid/ready interface, sequences select/op/addr/wdata
//  into the memory unit, waits its fixed latency, samples read data, returns a response.
//  Sits between the datapath/test host and the memory unit instance.
// PARAMETERS
//  ADDR_W     3  address width; must match memory unit (8 words)
//  DATA_W     8  data width
//  READ_LAT   2  cycles after the ISSUE cycle until mem_rdata is valid (>=1)
//  WRITE_LAT  2  cycles addr/wdata/op must stay stable after the ISSUE cycle (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready
//  req_we       in   1       1 = write, 0 = read
//  req_addr     in   ADDR_W  word address
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready
//  rsp_is_write out  1       response belongs to a write
//  rsp_rdata    out  DATA_W  read data (writes: 0, or readback with MEM_CTRL_VERIFY_EN)
//  rsp_err      out  1       readback mismatch (MEM_CTRL_VERIFY_EN only, else 0)
//  mem_select   out  1       to memory unit select; one-cycle pulse per access
//  mem_op       out  1       to memory unit op; 1 = write
//  mem_addr     out  ADDR_W  to memory unit addr
//  mem_wdata    out  DATA_W  to memory unit data_in
//  mem_rdata    in   DATA_W  from memory unit data_out
// BEHAVIOUR
//  - Reset: state IDLE; all outputs registered to 0; req_ready = (state==IDLE) & ~rst,
//    so 0 while rst high, 1 after release.
//  - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE (+ RB_ISSUE, RB_WAIT with verify).
//  - IDLE: req_ready=1; on handshake capture we/addr/wdata into internal regs -> ISSUE.
//  - ISSUE (exactly 1 cycle): mem_select=1, mem_op=we; load counter with LAT-1
//    (LAT = WRITE_LAT if write else READ_LAT) -> WAIT.
//  - mem_op/mem_addr/mem_wdata driven from captured regs; stable from ISSUE until next
//    request is captured. mem_select=0 in every state except ISSUE/RB_ISSUE.
//  - WAIT: counter decrements each cycle; at 0 -> RESP; reads sample mem_rdata into
//    rsp_rdata on that same edge (READ_LAT cycles after the ISSUE cycle).
//  - RESP: rsp_valid=1; rsp_* held stable until rsp_ready; on handshake -> IDLE,
//    rsp_valid=0 next cycle.
//  - Latency accept edge -> rsp_valid: LAT+2 cycles. Throughput with rsp_ready=1:
//    one access per LAT+3 cycles (IDLE not bypassed).
//  - req_ready=0 outside IDLE; req_valid while busy is ignored, requester holds it.
//  - Counter width $clog2(max(READ_LAT,WRITE_LAT))+1; no wrap (loaded, counts to 0).
//  - Reset mid-operation: transaction abandoned, mem_select/rsp_valid drop immediately,
//    no response emitted; word contents undefined if reset hits during write WAIT.
// CONFIGURATION
//  MEM_CTRL_VERIFY_EN defined: after a write's WAIT -> RB_ISSUE (select, op=0, same
//    addr) -> RB_WAIT (READ_LAT) -> RESP; rsp_rdata = readback, rsp_err = (readback !=
//    captured wdata). Write latency becomes WRITE_LAT+READ_LAT+3. Reads unchanged.
//  Not defined: no RB states; rsp_err tied 0; rsp_rdata = 0 for writes.
// TESTING
//  1 write 0xA5 @3, rsp_ready=1 -> mem_select 1 cycle, op=1, addr=3, wdata=0xA5;
//    rsp_valid 4 cycles after accept, rsp_is_write=1, rsp_err=0.
//  2 read @3 after test 1 -> rsp_rdata=0xA5, rsp_is_write=0, rsp_valid 4 cycles after accept.
//  3 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, second
//    request held; accepted the cycle after returning to IDLE.
//  4 rst pulse during read WAIT -> mem_select=0, rsp_valid=0, req_ready=0 while rst;
//    next read @3 completes normally with 0xA5.
//  5 writes 0x10+i @i for i=0..7 then reads @0..7 -> each read returns 0x10+i;
//    accept-to-accept spacing 5 cycles.
//  6 MEM_CTRL_VERIFY_EN, model forces bit0=1 @5: write 0x3C @5 -> rsp_err=1,
//    rsp_rdata=0x3D, rsp_valid 7 cycles after accept; macro off -> rsp_err=0.

Source files
------------

// File: rtl/memory_ctrl.sv
// Single-request initiator for the memory unit: valid/ready request in, fixed-latency access, held response out.
// Optional write readback check is compiled in with MEM_CTRL_VERIFY_EN.
module memory_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_is_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_select,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_RB_ISSUE,
    S_RB_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
`ifdef MEM_CTRL_VERIFY_EN
  logic               err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
`ifdef MEM_CTRL_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifdef MEM_CTRL_VERIFY_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
`ifdef MEM_CTRL_VERIFY_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = we_q ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (we_q) begin
`ifdef MEM_CTRL_VERIFY_EN
            state_d = S_RB_ISSUE;
`else
            rdata_d = '0;
            state_d = S_RESP;
`endif
          end else begin
            rdata_d = mem_rdata;
`ifdef MEM_CTRL_VERIFY_EN
            err_d   = 1'b0;
`endif
            state_d = S_RESP;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MEM_CTRL_VERIFY_EN
      S_RB_ISSUE: begin
        cnt_d   = CNT_W'(READ_LAT - 1);
        state_d = S_RB_WAIT;
      end
      S_RB_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          err_d   = (mem_rdata != wdata_q);
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Readback phases reuse the captured address but must present a read op.
  assign req_ready    = (state_q == S_IDLE) & ~rst;
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_is_write = we_q;
  assign rsp_rdata    = rdata_q;
  assign mem_select   = (state_q == S_ISSUE) | (state_q == S_RB_ISSUE);
  assign mem_op       = we_q & ~((state_q == S_RB_ISSUE) | (state_q == S_RB_WAIT));
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
`ifdef MEM_CTRL_VERIFY_EN
  assign rsp_err      = err_q;
`else
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_memory_ctrl.sv
// Bench for memory_ctrl: memory unit model with 2-cycle read pipeline, response scoreboard,
// table-driven write/read sweep and hand-written stall, reset and readback sequences.
module tb_memory_ctrl;

`ifdef MEM_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int WLAT   = 7;
`else
  localparam bit VERIFY = 1'b0;
  localparam int WLAT   = 4;
`endif
  localparam int RLAT = 4;

  logic       clk, rst;
  logic       req_valid, req_ready, req_we;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_is_write, rsp_err;
  logic [7:0] rsp_rdata;
  logic       mem_select, mem_op;
  logic [2:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  memory_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_is_write(rsp_is_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_select(mem_select), .mem_op(mem_op), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory unit model: write on select edge, read data appears two cycles after the select cycle.
  logic [7:0] mem [8];
  logic [7:0] rd_s1, rd_s2;
  bit         stuck_en;
  always @(posedge clk) begin
    if (mem_select && mem_op)
      mem[mem_addr] <= (stuck_en && mem_addr == 3'd5) ? (mem_wdata | 8'h01) : mem_wdata;
    rd_s1 <= (mem_select && !mem_op) ? mem[mem_addr] : 8'hEE;
    rd_s2 <= rd_s1;
  end
  assign mem_rdata = rd_s2;

  typedef struct {
    bit       is_write;
    bit [7:0] rdata;
    bit       err;
    int       lat;
  } exp_t;

  typedef struct {
    bit       we;
    bit [2:0] addr;
    bit [7:0] wdata;
    bit [7:0] exp_rdata;
    bit       exp_err;
  } vec_t;

  exp_t exp_q[$];
  int   cmp_cnt = 0, err_cnt = 0;
  int   cyc = 0, acc_cnt = 0, rsp_cnt = 0;
  int   last_acc = 0, prev_acc = 0;
  int   sel_in_txn = 0;
  bit   first_op;
  bit [2:0] first_addr;
  bit [7:0] first_wdata;
  bit   prev_rv = 1'b0, prev_sel = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: monitor/scoreboard at the falling edge, return 1ns after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      prev_rv  = 1'b0;
      prev_sel = 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        prev_acc   = last_acc;
        last_acc   = cyc;
        sel_in_txn = 0;
        acc_cnt++;
      end
      if (mem_select) begin
        if (sel_in_txn == 0) begin
          first_op    = mem_op;
          first_addr  = mem_addr;
          first_wdata = mem_wdata;
          chk("select_cycle", cyc - last_acc, 1);
        end
        if (prev_sel) chk("select_pulse_width", 2, 1);
        sel_in_txn++;
      end
      if (rsp_valid && !prev_rv) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else chk("rsp_latency", cyc - last_acc, exp_q[0].lat);
      end
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rdata));
        chk("rsp_is_write", int'(rsp_is_write), int'(e.is_write));
        chk("rsp_err", int'(rsp_err), int'(e.err));
        rsp_cnt++;
      end
      prev_rv  = rsp_valid;
      prev_sel = mem_select;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input bit we, input bit [7:0] er, input bit ee);
    exp_t e;
    e.is_write = we;
    e.rdata    = er;
    e.err      = ee;
    e.lat      = we ? WLAT : RLAT;
    exp_q.push_back(e);
  endtask

  task automatic wait_accept();
    int a0;
    a0 = acc_cnt;
    for (int k = 0; k < 100 && acc_cnt == a0; k++) tick();
    if (acc_cnt == a0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int target);
    for (int k = 0; k < 100 && rsp_cnt < target; k++) tick();
    if (rsp_cnt < target) chk("rsp_timeout", rsp_cnt, target);
  endtask

  task automatic send(input bit we, input bit [2:0] a, input bit [7:0] d,
                      input bit [7:0] er, input bit ee);
    int target;
    target = rsp_cnt + 1;
    push_exp(we, er, ee);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    wait_accept();
    req_valid = 1'b0;
    wait_rsp(target);
  endtask

  vec_t vec[16];
  int   h, target;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; stuck_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vec[i].we        = (i < 8);
      vec[i].addr      = 3'(i % 8);
      vec[i].wdata     = 8'(8'h10 + (i % 8));
      vec[i].exp_rdata = (i < 8 && !VERIFY) ? 8'h00 : 8'(8'h10 + (i % 8));
      vec[i].exp_err   = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", int'(req_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_mem_select", int'(mem_select), 0);
    chk("reset_mem_op", int'(mem_op), 0);
    chk("reset_mem_addr", int'(mem_addr), 0);
    chk("reset_mem_wdata", int'(mem_wdata), 0);
    chk("reset_rsp_rdata", int'(rsp_rdata), 0);
    chk("reset_rsp_err", int'(rsp_err), 0);
    rst = 1'b0;
    #1;
    chk("release_req_ready", int'(req_ready), 1);
    tick();

    // Basic write then read back.
    send(1'b1, 3'd3, 8'hA5, VERIFY ? 8'hA5 : 8'h00, 1'b0);
    chk("wr_mem_op", int'(first_op), 1);
    chk("wr_mem_addr", int'(first_addr), 3);
    chk("wr_mem_wdata", int'(first_wdata), 8'hA5);
    chk("wr_select_count", sel_in_txn, VERIFY ? 2 : 1);
    send(1'b0, 3'd3, 8'h00, 8'hA5, 1'b0);
    chk("rd_mem_op", int'(first_op), 0);

    // Response stalled for 5 cycles with a second request waiting.
    rsp_ready = 1'b0;
    target = rsp_cnt + 2;
    push_exp(1'b0, 8'hA5, 1'b0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; req_wdata = 8'h00;
    wait_accept();
    push_exp(1'b0, 8'hA5, 1'b0);
    for (int k = 0; k < 20 && !rsp_valid; k++) tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", int'(rsp_valid), 1);
      chk("stall_rsp_rdata", int'(rsp_rdata), 8'hA5);
      chk("stall_req_ready", int'(req_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    h = cyc;
    wait_accept();
    chk("held_req_accept_cycle", last_acc, h + 1);
    req_valid = 1'b0;
    wait_rsp(target);

    // Reset during read WAIT: transaction abandoned, no response.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
    wait_accept();
    req_valid = 1'b0;
    tick();
    exp_q.delete();
    rst = 1'b1;
    #1;
    chk("rst_mem_select", int'(mem_select), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    tick();
    tick();
    chk("rst_hold_req_ready", int'(req_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_release_req_ready", int'(req_ready), 1);
    tick();
    send(1'b0, 3'd3, 8'h00, 8'hA5, 1'b0);

    // Table sweep: writes 0x10+i then reads, checking accept spacing.
    for (int i = 0; i < 16; i++) begin
      send(vec[i].we, vec[i].addr, vec[i].wdata, vec[i].exp_rdata, vec[i].exp_err);
      if (i > 0) chk("accept_spacing", last_acc - prev_acc, (vec[i-1].we ? WLAT : RLAT) + 1);
    end

    // Stuck bit at address 5 exposed only by readback.
    stuck_en = 1'b1;
    send(1'b1, 3'd5, 8'h3C, VERIFY ? 8'h3D : 8'h00, VERIFY);
    stuck_en = 1'b0;
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
